// File: rtl/rst_seq_synch_if.sv
`default_nettype none
// ============================================================================
//  Module      : rst_seq_synch_if
//  Description : Software-request and sequenced-reset bundle for the reset
//                synchroniser/sequencer.
//                  sw_rst_req - synchronous software reset request (to block)
//                  rst_n_out  - sequenced active-low resets, bit 0 first
//                  rst_done   - all rst_n_out bits released
//                  sw_cause   - 1 = last reset was software-initiated
//                The master modport belongs to the requester and consumers.
//                The slave modport belongs to the sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rst_seq_synch_if #(
  parameter int NUM_OUT = 3
);
  logic               sw_rst_req;
  logic [NUM_OUT-1:0] rst_n_out;
  logic               rst_done;
  logic               sw_cause;

  modport master (
    output sw_rst_req,
    input  rst_n_out,
    input  rst_done,
    input  sw_cause
  );

  modport slave (
    input  sw_rst_req,
    output rst_n_out,
    output rst_done,
    output sw_cause
  );
endinterface
`default_nettype wire

// File: rtl/rst_seq_synch.sv
`default_nettype none
// ============================================================================
//  Module      : rst_seq_synch
//  Description : Reset synchroniser and sequencer. The asynchronous board
//                reset RST_n is asserted asynchronously. Its deassertion is
//                synchronised through a SYNC_STAGES flop chain. The block then
//                holds reset for HOLD_CYCLES edges and releases NUM_OUT reset
//                outputs one at a time, STAGGER edges apart. A synchronous
//                software request restarts the sequence and records the cause.
//  Ports       : clk        - clock; the active edge is selected by NEG_EDGE
//                RST_n      - board reset, asynchronous, active-low
//                bus        - slave side of rst_seq_synch_if
//                             (sw_rst_req, rst_n_out, rst_done, sw_cause)
//  Revision    : 1.0 - initial release
// ============================================================================
module rst_seq_synch #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_OUT     = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGGER     = 4,
  parameter bit NEG_EDGE    = 1'b1
) (
  input  wire logic       clk,
  input  wire logic       RST_n,
  rst_seq_synch_if.slave  bus
);

  localparam int c_MAX_CNT = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
  localparam int c_CW      = $clog2(c_MAX_CNT) + 1;

  localparam logic [c_CW-1:0] c_HOLD_LAST = c_CW'(HOLD_CYCLES - 1);
  localparam logic [c_CW-1:0] c_STAG_LAST = c_CW'(STAGGER - 1);
  localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Every flop of the block lives in this record. Its all-zero value is the
  // pin-reset state, with the FSM in HOLD.
  typedef struct packed {
    logic [SYNC_STAGES-1:0] sync;
    state_t                 state;
    logic [c_CW-1:0]        cnt;
    logic [NUM_OUT-1:0]     rst_n;
    logic                   done;
    logic                   cause;
    logic                   pend;   // software request seen, not yet dropped
  } seq_t;

  seq_t               r_q;
  seq_t               w_d;
  logic               w_sync_q;
  logic [NUM_OUT-1:0] w_rel_next;

  assign w_sync_q = r_q.sync[SYNC_STAGES-1];

  // The released bits form a thermometer code. Shifting in a 1 releases the
  // next bit in order.
  generate
    if (NUM_OUT > 1) begin : g_shift_multi
      assign w_rel_next = {r_q.rst_n[NUM_OUT-2:0], 1'b1};
    end else begin : g_shift_single
      assign w_rel_next = 1'b1;
    end
  endgenerate

  always_comb begin
    w_d      = r_q;
    w_d.sync = {r_q.sync[SYNC_STAGES-2:0], 1'b1};

    if (w_sync_q && bus.sw_rst_req) begin
      // A software request wins over any release scheduled on this edge.
      w_d.state = HOLD;
      w_d.cnt   = '0;
      w_d.rst_n = '0;
      w_d.done  = 1'b0;
      w_d.cause = 1'b1;
      w_d.pend  = 1'b1;
    end else begin
      case (r_q.state)
        HOLD: begin
          if (r_q.pend) begin
            // This is the first edge with the request dropped. The count
            // starts on the following edge, so the software hold matches the
            // power-on hold measured from sync_q rising.
            w_d.pend = 1'b0;
          end else if (w_sync_q) begin
            if (r_q.cnt == c_HOLD_LAST) begin
              w_d.rst_n = w_rel_next;
              w_d.cnt   = '0;
              w_d.state = w_rel_next[NUM_OUT-1] ? DONE : RELEASE;
              w_d.done  = w_rel_next[NUM_OUT-1];
            end else begin
              w_d.cnt = r_q.cnt + c_CNT_ONE;
            end
          end
        end
        RELEASE: begin
          if (r_q.cnt == c_STAG_LAST) begin
            w_d.rst_n = w_rel_next;
            w_d.cnt   = '0;
            w_d.state = w_rel_next[NUM_OUT-1] ? DONE : RELEASE;
            w_d.done  = w_rel_next[NUM_OUT-1];
          end else begin
            w_d.cnt = r_q.cnt + c_CNT_ONE;
          end
        end
        DONE: begin
          w_d.done = 1'b1;
        end
        default: begin
          w_d.state = HOLD;
          w_d.cnt   = '0;
        end
      endcase
    end
  end

  // Only the clock edge differs between the two variants. All outputs are
  // taken straight from these flops.
  generate
    if (NEG_EDGE) begin : g_negedge
      always_ff @(negedge clk or negedge RST_n) begin
        if (!RST_n) r_q <= '0;
        else        r_q <= w_d;
      end
    end else begin : g_posedge
      always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) r_q <= '0;
        else        r_q <= w_d;
      end
    end
  endgenerate

  assign bus.rst_n_out = r_q.rst_n;
  assign bus.rst_done  = r_q.done;
  assign bus.sw_cause  = r_q.cause;

endmodule
`default_nettype wire

// File: doc/rst_seq_synch.md
Name: rst_seq_synch

Overview:
- Parametrised reset synchroniser and sequencer.
- Takes the asynchronous, active-low board reset and synchronises its deassertion to clk through a configurable-depth flop chain.
- Holds reset for a programmable number of cycles, then releases NUM_OUT reset outputs in a staggered order. Downstream blocks (motor drive, sensor interface, command FSM) therefore come out of reset in a known sequence.
- Also accepts a synchronous software reset request and reports completion and reset cause.

Parameters:
- SYNC_STAGES, 2, depth of the deassertion synchroniser chain (legal: >=2)
- NUM_OUT, 3, number of sequenced reset outputs (legal: >=1)
- HOLD_CYCLES, 16, active clock edges between synchroniser release and rst_n_out[0] release (legal: >=1)
- STAGGER, 4, active edges between release of rst_n_out[i] and rst_n_out[i+1] (legal: >=1)
- NEG_EDGE, 1, 1 = all flops clock on falling clk edge; 0 = rising edge

Ports:
- clk  input  1  system clock; the active edge is selected by NEG_EDGE
- RST_n  input  1  reset, asynchronous, active-low
- sw_rst_req  input  1  synchronous software reset request, level-sensitive, sampled on the active edge
- rst_n_out  output  NUM_OUT  sequenced active-low resets; bit 0 is released first
- rst_done  output  1  high when all rst_n_out bits are released
- sw_cause  output  1  1 = last reset was software-initiated; 0 = pin reset

Behaviour:
- Assertion, RST_n low:
  - All flops clear asynchronously, with no clock required.
  - rst_n_out = 0, rst_done = 0, sw_cause = 0.
  - Synchroniser chain = 0; FSM = HOLD; counter = 0.
- Deassertion:
  - The synchroniser chain shifts in 1 on each active edge.
  - Let E1 be the first active edge that samples RST_n high. The chain output sync_q rises at E_SYNC_STAGES.
  - Deassertion is never passed through combinationally.
- FSM states: HOLD, RELEASE, DONE.
  - HOLD: counter advances only while sync_q = 1. When an edge sees counter == HOLD_CYCLES-1, set rst_n_out[0] = 1 and counter = 0, then go to RELEASE. With NUM_OUT = 1, go directly to DONE instead.
  - RELEASE: the counter advances every edge. When an edge sees counter == STAGGER-1, release the next output bit and clear the counter. On the edge that releases bit NUM_OUT-1, go to DONE.
  - DONE: rst_done = 1, asserted on the same edge as the final bit release. Outputs stay stable.
- Release timing, relative to E1:
  - rst_n_out[i] rises at E(SYNC_STAGES + HOLD_CYCLES + i*STAGGER).
  - rst_done rises with bit NUM_OUT-1.
- Output integrity:
  - All outputs come straight from flops; no combinational logic follows them, so there are no glitches.
  - Released bits never re-assert except through reset (pin or software).
- Software reset, sw_rst_req = 1 sampled on an active edge while sync_q = 1:
  - All rst_n_out clear synchronously on that edge; rst_done = 0; sw_cause = 1.
  - FSM goes to HOLD with counter = 0.
  - While sw_rst_req stays high, the counter is held at 0.
  - The hold count starts on the first edge that samples sw_rst_req low. rst_n_out[0] then rises HOLD_CYCLES edges after that edge.
  - This applies in every state: a request in HOLD restarts the count; a request in RELEASE drops the released bits.
  - The synchroniser chain is not affected.
- sw_cause:
  - Cleared only by pin reset.
  - Set by an accepted software request.
  - Holds its value otherwise, including after the sequence completes.
- Pin reset mid-sequence: RST_n low at any time, in any state or during a software reset, asynchronously returns everything to the reset values above. This includes a glitch shorter than one clock period.
- sw_rst_req while sync_q = 0: ignored; sw_cause is unchanged.
- Counter width: $clog2 of the larger of HOLD_CYCLES and STAGGER, plus 1. The counter never wraps in normal operation.
- Simultaneous events: RST_n low takes priority over sw_rst_req, and sw_rst_req takes priority over a release scheduled on the same edge.

Test Plan (default parameters unless noted):
- Power-on: RST_n low 5 cycles, then high → rst_n_out stays 3'b000 through E17. Bit 0 rises at E18, bit 1 at E22, bit 2 at E26; rst_done rises at E26; sw_cause = 0.
- Async assert: RST_n driven low mid-cycle at E23, with bits 0 and 1 released → rst_n_out = 0 and rst_done = 0 immediately, before the next edge. Deassert and re-check the E18/E22/E26 sequence.
- Glitch: RST_n low for 1/4 clock period while in DONE → full reset, then a complete sequence of 26 edges; sw_cause = 0.
- Software reset: in DONE, sw_rst_req high for 3 edges, low from edge S → on the first request edge rst_n_out = 0, rst_done = 0, sw_cause = 1. Bit 0 rises at S+16, bit 1 at S+20, bit 2 at S+24.
- Request during RELEASE at E24 (bits 0 and 1 released) → both bits drop at E24 and the hold count restarts. A request sampled while sync_q = 0 (edge E1) is ignored.
- Parameter sweep: NUM_OUT=1, SYNC_STAGES=3, HOLD_CYCLES=1, and NEG_EDGE=0 versus 1 → rst_n_out[0] and rst_done rise together at E4, on the selected clock edge.
